// File: rtl/up_frame_collector.sv
// up_frame_collector
//   Collects 64-bit words from the PAICore upstream transport stage into a
//   show-ahead FIFO and forwards them to the DMA S2MM slave. The all-ones
//   end-of-receive marker is swallowed and replaced by a status trailer
//   {16'hFFFF, 13'b0, timeout, abort, no_marker, word_count} carrying tlast,
//   so every DMA frame closes on a meaningful word.
//
//   Optional feature macro: UP_TIMEOUT_EN (idle watchdog that injects the
//   trailer after TIMEOUT_CYCLES idle cycles once a word has been seen).
//
// Ports
//   s_axis_aclk, s_axis_aresetn : clock, async active-low reset
//   i_rx_rcving                 : receive session active
//   s_axis_*                    : upstream AXI-Stream slave (64-bit)
//   m_axis_*                    : downstream AXI-Stream master to DMA
//   o_rx_complete               : pulse on trailer handshake at m_axis
//   o_word_count                : data words accepted this session
//   o_busy                      : FSM not idle or FIFO not empty
module up_frame_collector #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic        i_rx_rcving,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        o_rx_complete,
  output logic [31:0] o_word_count,
  output logic        o_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, STREAM, TRAILER, DONE} state_t;

  state_t      state;
  logic [64:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        fifo_empty;
  logic [64:0] head;

  logic        abort_f;
  logic        no_marker_f;
  logic        timeout_f;
  logic        timeout_hit;

  logic        s_hs;
  logic        m_hs;
  logic        is_marker;
  logic        push;
  logic        pop;
  logic [64:0] wdata;
  logic [63:0] trailer;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];

  assign s_axis_tready = (state == STREAM) && !fifo_full && i_rx_rcving;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : head[63:0];
  assign m_axis_tlast  = !fifo_empty && head[64];
  assign o_rx_complete = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign o_busy        = (state != IDLE) || !fifo_empty;

  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign m_hs      = m_axis_tvalid && m_axis_tready;
  assign is_marker = s_axis_tlast && (s_axis_tdata == '1);
  assign trailer   = {16'hFFFF, 13'd0, timeout_f, abort_f, no_marker_f, o_word_count};

  // Data pushes happen only in STREAM and trailer pushes only in TRAILER,
  // so the two sources never collide.
  always_comb begin
    push  = 1'b0;
    wdata = {1'b0, s_axis_tdata};
    if (s_hs && !is_marker) begin
      push = 1'b1;
    end else if (state == TRAILER && !fifo_full) begin
      push  = 1'b1;
      wdata = {1'b1, trailer};
    end
  end

  assign pop = m_hs;

  always_ff @(posedge s_axis_aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

`ifdef UP_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        seen_word;

  // Rcving falling has priority: it produces an abort trailer, not a timeout.
  assign timeout_hit = (state == STREAM) && seen_word && !s_hs && i_rx_rcving &&
                       ((idle_cnt + 32'd1) == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      idle_cnt  <= '0;
      seen_word <= 1'b0;
      timeout_f <= 1'b0;
    end else if (state == IDLE) begin
      if (i_rx_rcving) begin
        idle_cnt  <= '0;
        seen_word <= 1'b0;
        timeout_f <= 1'b0;
      end
    end else if (state == STREAM) begin
      if (s_hs) begin
        idle_cnt  <= '0;
        seen_word <= 1'b1;
      end else if (seen_word) begin
        idle_cnt <= idle_cnt + 32'd1;
        if (timeout_hit) timeout_f <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_f   = 1'b0;
`endif

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state        <= IDLE;
      o_word_count <= '0;
      abort_f      <= 1'b0;
      no_marker_f  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_rx_rcving) begin
            state        <= STREAM;
            o_word_count <= '0;
            abort_f      <= 1'b0;
            no_marker_f  <= 1'b0;
          end
        end
        STREAM: begin
          if (s_hs) begin
            if (!is_marker && o_word_count != '1)
              o_word_count <= o_word_count + 32'd1;
            if (s_axis_tlast) begin
              state <= TRAILER;
              if (!is_marker) no_marker_f <= 1'b1;
            end
          end else if (!i_rx_rcving) begin
            abort_f <= 1'b1;
            state   <= TRAILER;
          end else if (timeout_hit) begin
            state <= TRAILER;
          end
        end
        TRAILER: begin
          if (!fifo_full) state <= DONE;
        end
        DONE: begin
          if (!i_rx_rcving && fifo_empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
